// File: rtl/vin_quadencoder_index_ctrl.sv
// Quadrature position counter with an armable index latch; QUADENC_INDEX_ZERO_EN zeroes the count on latch.
// Latency: 3 clk from a phase or index edge to pos / flags; no flow control, every input sampled each cycle.
module vin_quadencoder_index_ctrl #(
    parameter int BITS      = 32,
    parameter int QUAD_TYPE = 0,
    parameter int IDX_POL   = 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   quadA,
    input  logic                   quadB,
    input  logic                   index,
    input  logic                   arm,
    input  logic                   clear,
    output logic signed [BITS-1:0] pos,
    output logic signed [BITS-1:0] latched_pos,
    output logic                   armed,
    output logic                   latch_valid
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ARMED = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    logic [2:0]             r_a;
    logic [2:0]             r_b;
    logic [2:0]             r_i;
    logic signed [BITS-1:0] r_count;
    logic signed [BITS-1:0] r_latched;
    state_t                 r_state;
    state_t                 w_state_nxt;
    logic                   r_armed;
    logic                   r_latch_valid;
    logic                   w_idx_raw;
    logic                   w_step;
    logic                   w_up;
    logic                   w_idx_edge;
    logic                   w_capture;

    // Normalise the index to active-high before it enters the synchroniser.
    assign w_idx_raw = (IDX_POL != 0) ? index : ~index;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a <= 3'b000;
            r_b <= 3'b000;
            r_i <= 3'b000;
        end else begin
            r_a <= {r_a[1:0], quadA};
            r_b <= {r_b[1:0], quadB};
            r_i <= {r_i[1:0], w_idx_raw};
        end
    end

    assign w_step     = r_a[1] ^ r_a[2] ^ r_b[1] ^ r_b[2];
    assign w_up       = r_a[1] ^ r_b[2];
    assign w_idx_edge = r_i[1] & ~r_i[2];

    always_comb begin
        w_state_nxt = r_state;
        w_capture   = 1'b0;
        if (clear) begin
            w_state_nxt = S_IDLE;
        end else begin
            unique case (r_state)
                S_IDLE:  if (arm) w_state_nxt = S_ARMED;
                S_ARMED: if (w_idx_edge) begin
                    w_state_nxt = S_DONE;
                    w_capture   = 1'b1;
                end
                S_DONE:  if (arm) w_state_nxt = S_ARMED;
                default: w_state_nxt = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= S_IDLE;
            r_armed       <= 1'b0;
            r_latch_valid <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_armed       <= (w_state_nxt == S_ARMED);
            r_latch_valid <= (w_state_nxt == S_DONE);
        end
    end

    // The latch sees the count as it stood before this cycle's step.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count   <= '0;
            r_latched <= '0;
        end else begin
            if (w_capture) r_latched <= r_count;
`ifdef QUADENC_INDEX_ZERO_EN
            if (w_capture)   r_count <= '0;
            else if (w_step) r_count <= w_up ? r_count + 1'b1 : r_count - 1'b1;
`else
            if (w_step)      r_count <= w_up ? r_count + 1'b1 : r_count - 1'b1;
`endif
        end
    end

    assign pos         = r_count >>> QUAD_TYPE;
    assign latched_pos = r_latched >>> QUAD_TYPE;
    assign armed       = r_armed;
    assign latch_valid = r_latch_valid;

endmodule

// File: tb/tb_vin_quadencoder_index_ctrl.sv
// Scoreboard bench for vin_quadencoder_index_ctrl (8-bit count so wrap is reachable).
module tb_vin_quadencoder_index_ctrl;

    localparam int TB_BITS = 8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic quadA = 1'b0, quadB = 1'b0, index = 1'b0, arm = 1'b0, clear = 1'b0;
    logic signed [TB_BITS-1:0] pos, latched_pos;
    logic armed, latch_valid;

    vin_quadencoder_index_ctrl #(.BITS(TB_BITS), .QUAD_TYPE(0), .IDX_POL(1)) dut (
        .clk(clk), .rst_n(rst_n), .quadA(quadA), .quadB(quadB), .index(index),
        .arm(arm), .clear(clear), .pos(pos), .latched_pos(latched_pos),
        .armed(armed), .latch_valid(latch_valid)
    );

    always #5 clk = ~clk;

    typedef struct {
        string      tag;
        int         sel;
        logic [31:0] val;
    } exp_t;

    exp_t q_exp[$];
    int n_total = 0;
    int n_bad   = 0;

    // model state: 0 idle, 1 armed, 2 done
    int          m_st = 0;
    logic [7:0]  m_cnt = 8'h00;
    logic [7:0]  m_lat = 8'h00;
    int          ph = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] sample(input int sel);
        case (sel)
            0:       return {24'b0, pos};
            1:       return {24'b0, latched_pos};
            2:       return {31'b0, armed};
            default: return {31'b0, latch_valid};
        endcase
    endfunction

    task automatic push(input string tag, input int sel, input logic [31:0] val);
        exp_t e;
        e.tag = tag; e.sel = sel; e.val = val;
        q_exp.push_back(e);
    endtask

    task automatic push_flags(input string tag);
        push({tag, "_armed"}, 2, {31'b0, m_st == 1});
        push({tag, "_lv"},    3, {31'b0, m_st == 2});
    endtask

    task automatic drain();
        exp_t e;
        while (q_exp.size() > 0) begin
            e = q_exp.pop_front();
            chk(e.tag, sample(e.sel), e.val);
        end
    endtask

    task automatic drive_phase();
        case (ph)
            0: begin quadA = 1'b0; quadB = 1'b0; end
            1: begin quadA = 1'b1; quadB = 1'b0; end
            2: begin quadA = 1'b1; quadB = 1'b1; end
            default: begin quadA = 1'b0; quadB = 1'b1; end
        endcase
    endtask

    task automatic step(input bit fwd, input bit do_chk, input bit lat_chk);
        @(negedge clk);
        ph = fwd ? (ph + 1) % 4 : (ph + 3) % 4;
        drive_phase();
        repeat (2) @(posedge clk);
        if (lat_chk) begin
            #1;
            push("lat_pos_early", 0, {24'b0, m_cnt});
            drain();
        end
        @(posedge clk);
        #1;
        m_cnt = fwd ? m_cnt + 8'd1 : m_cnt - 8'd1;
        if (do_chk) begin
            push("step_pos", 0, {24'b0, m_cnt});
            drain();
        end
    endtask

    task automatic arm_clear(input logic a, input logic c, input string tag);
        @(negedge clk);
        arm = a; clear = c;
        @(posedge clk);
        #1;
        if (c) m_st = 0;
        else if (a && m_st != 1) m_st = 1;
        push_flags(tag);
        drain();
        @(negedge clk);
        arm = 1'b0; clear = 1'b0;
    endtask

    task automatic idx_pulse(input string tag);
        @(negedge clk);
        index = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        push_flags({tag, "_pre"});
        drain();
        @(posedge clk);
        #1;
        if (m_st == 1) begin
            m_st  = 2;
            m_lat = m_cnt;
`ifdef QUADENC_INDEX_ZERO_EN
            m_cnt = 8'h00;
`endif
        end
        push_flags(tag);
        push({tag, "_lat"}, 1, {24'b0, m_lat});
        push({tag, "_pos"}, 0, {24'b0, m_cnt});
        drain();
        @(negedge clk);
        index = 1'b0;
        repeat (4) @(posedge clk);
    endtask

    task automatic do_reset(input string tag);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        quadA = 1'b0; quadB = 1'b0; index = 1'b0; arm = 1'b0; clear = 1'b0;
        ph = 0;
        #1;
        m_st = 0; m_cnt = 8'h00; m_lat = 8'h00;
        push({tag, "_pos"}, 0, 32'h0);
        push({tag, "_lat"}, 1, 32'h0);
        push_flags(tag);
        drain();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        do_reset("reset");

        // 8 forward then 8 reverse, first step also checks 3-cycle latency
        step(1'b1, 1'b1, 1'b1);
        for (int i = 1; i < 8; i++) step(1'b1, 1'b1, 1'b0);
        push("fwd8", 0, 32'd8); drain();
        for (int i = 0; i < 8; i++) step(1'b0, 1'b1, 1'b0);
        push("rev8", 0, 32'd0); drain();

        // underflow to all ones, then back up to the positive limit and wrap
        step(1'b0, 1'b1, 1'b0);
        push("neg1", 0, 32'h0000_00ff); drain();
        step(1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 127; i++) step(1'b1, 1'b0, 1'b0);
        push("maxpos", 0, 32'h0000_007f); drain();
        step(1'b1, 1'b0, 1'b0);
        push("wrap", 0, 32'h0000_0080); drain();

        // latch at pos=100
        do_reset("reset2");
        for (int i = 0; i < 100; i++) step(1'b1, 1'b0, 1'b0);
        push("pos100", 0, 32'd100); drain();
        idx_pulse("idx_idle");
        arm_clear(1'b1, 1'b0, "arm");
        arm_clear(1'b1, 1'b0, "arm_again");
        idx_pulse("idx_latch");
        step(1'b1, 1'b1, 1'b0);
        idx_pulse("idx_done");
        arm_clear(1'b1, 1'b0, "rearm");
        arm_clear(1'b0, 1'b1, "clear_armed");
        idx_pulse("idx_cleared");

        // arm and clear together: clear wins
        arm_clear(1'b1, 1'b1, "arm_clr");
        idx_pulse("idx_after_armclr");

        // move to 57 and latch (homing variant zeroes the count)
        while (m_cnt != 8'd57) step(m_cnt < 8'd57, 1'b0, 1'b0);
        push("pos57", 0, 32'd57); drain();
        arm_clear(1'b1, 1'b0, "arm57");
        idx_pulse("idx57");
        step(1'b1, 1'b1, 1'b0);

        // reset while armed discards the arm
        do_reset("reset3");
        for (int i = 0; i < 20; i++) step(1'b1, 1'b0, 1'b0);
        push("pos20", 0, 32'd20); drain();
        arm_clear(1'b1, 1'b0, "arm20");
        do_reset("rst_armed");
        idx_pulse("idx_after_rst");

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
